regfile_scanner: RTL and testbench

REGFILE_SCANNER -- requirements
Module: regfile_scanner

---
 rtl/regfile_scanner_if.sv | 38 +++
 rtl/regfile_scanner.sv | 124 ++++++++++++
 tb/tb_regfile_scanner.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scanner_if.sv
// Purpose: bundles the scanner's control, register-file read port and output word stream.
// Latency: none, wiring only.
// Backpressure: out_valid/out_ready pair; a word holds until out_valid && out_ready.
//
// Ports (master = scanner side):
//   start, abort, first_addr, last_addr : scan control from the requester
//   rd_addr -> / rd_data <-             : one combinational register-file read port
//   out_valid, out_ready, out_data,
//   out_index, out_last                 : captured word stream to the consumer
//   busy, done                          : status
interface regfile_scanner_if #(
    parameter int n = 32,
    parameter int r = 5
);
    logic         start;
    logic         abort;
    logic [r-1:0] first_addr;
    logic [r-1:0] last_addr;
    logic [r-1:0] rd_addr;
    logic [n-1:0] rd_data;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] out_data;
    logic [r-1:0] out_index;
    logic         out_last;
    logic         busy;
    logic         done;

    modport master (
        input  start, abort, first_addr, last_addr, rd_data, out_ready,
        output rd_addr, out_valid, out_data, out_index, out_last, busy, done
    );

    modport slave (
        output start, abort, first_addr, last_addr, rd_data, out_ready,
        input  rd_addr, out_valid, out_data, out_index, out_last, busy, done
    );
endinterface

// File: rtl/regfile_scanner.sv
// Purpose: walks register indices first_addr..last_addr and streams each value out.
// Latency: word k presented 2k+1 edges after the accepting start edge; done follows the last handshake by one cycle.
// Backpressure: out_ready low holds the captured word; at most one word per two cycles.
//
// Ports: clk, rst (async active-high) plus bus (regfile_scanner_if.master):
//   start/abort/first_addr/last_addr in, rd_addr out / rd_data in,
//   out_valid/out_data/out_index/out_last out with out_ready in, busy/done out.
module regfile_scanner #(
    parameter int n = 32,
    parameter int r = 5
) (
    input  logic               clk,
    input  logic               rst,
    regfile_scanner_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [r-1:0] ptr;
    logic [r-1:0] end_ptr;
    logic         accept;

    // abort in IDLE suppresses a same-cycle start.
    assign accept = (state == IDLE) && bus.start && !bus.abort;

    // rd_data feeds only the capture register, never an output directly.
    assign bus.rd_addr = ptr;
    assign bus.busy    = (state != IDLE);
    // An abort landing in FINISH cancels the completion pulse.
    assign bus.done    = (state == FINISH) && !bus.abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (bus.first_addr <= bus.last_addr) ? FETCH : FINISH;
                end
            end
            FETCH: begin
                state_nxt = bus.abort ? IDLE : HOLD;
            end
            HOLD: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.out_ready) begin
                    state_nxt = bus.out_last ? FINISH : FETCH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= '0;
            end_ptr       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_index <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr     <= bus.first_addr;
                        end_ptr <= bus.last_addr;
                    end
                end
                FETCH: begin
                    if (bus.abort) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                    end else begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= bus.rd_data;
                        bus.out_index <= ptr;
                        bus.out_last  <= (ptr == end_ptr);
                    end
                end
                HOLD: begin
                    if (bus.abort) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        // Stop at end_ptr so a scan ending at the top index never wraps.
                        if (!bus.out_last) begin
                            ptr <= ptr + {{(r-1){1'b0}}, 1'b1};
                        end
                    end
                end
                FINISH: begin
                    if (bus.abort) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_scanner.sv
module tb_regfile_scanner;
    localparam int N = 32;
    localparam int R = 5;
    localparam int DEPTH = 2**R;

    logic clk;
    logic rst;

    regfile_scanner_if #(.n(N), .r(R)) bus();

    regfile_scanner #(.n(N), .r(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural register file with a combinational read port.
    logic [N-1:0] x [DEPTH];
    assign bus.rd_data = x[bus.rd_addr];

    typedef struct {
        logic [R-1:0] idx;
        logic [N-1:0] data;
        logic         last;
    } exp_t;

    exp_t sb[$];

    int checks     = 0;
    int errors     = 0;
    int done_cnt   = 0;
    int busy_cyc   = 0;
    int stall4     = 0;
    int rdy_mode   = 0;   // 0/3: bench drives out_ready directly, 1: random, 2: stall on index 4
    int stall_left = 0;

    bit           held;
    logic [N-1:0] h_data;
    logic [R-1:0] h_idx;
    logic         h_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a scan emits every index first..last inclusive, in order,
    // with the register value present when the scan was issued; last flags the final one.
    function automatic void model_scan(input int f, input int l);
        for (int i = f; i <= l; i++) begin
            exp_t e;
            e.idx  = i[R-1:0];
            e.data = x[i];
            e.last = (i == l);
            sb.push_back(e);
        end
    endfunction

    task automatic do_start(input int f, input int l, input bit accepted);
        bus.first_addr = f[R-1:0];
        bus.last_addr  = l[R-1:0];
        bus.start      = 1'b1;
        if (accepted) model_scan(f, l);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.busy && k < budget);
        chk({name, "_timeout"}, {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic tick_p;
        @(posedge clk);
        #1;
    endtask

    // Ready generator for the random and targeted-stall modes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end else if (rdy_mode == 2) begin
                if (bus.out_valid && bus.out_index == 5'd4 && stall_left > 0) begin
                    bus.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks hold stability.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held && bus.out_valid) begin
                chk("hold_stable", {26'd0, bus.out_index, bus.out_data, bus.out_last},
                    {26'd0, h_idx, h_data, h_last});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got index %0d data 0x%0h, required none",
                             bus.out_index, bus.out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word", {26'd0, bus.out_index, bus.out_data, bus.out_last},
                        {26'd0, e.idx, e.data, e.last});
                end
            end
            held   = bus.out_valid && !bus.out_ready;
            h_data = bus.out_data;
            h_idx  = bus.out_index;
            h_last = bus.out_last;
            if (bus.out_valid && !bus.out_ready && bus.out_index == 5'd4) stall4++;
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({name, "_out_data"},  {32'd0, bus.out_data},  64'd0);
        chk({name, "_out_index"}, {59'd0, bus.out_index}, 64'd0);
        chk({name, "_out_last"},  {63'd0, bus.out_last},  64'd0);
        chk({name, "_busy"},      {63'd0, bus.busy},      64'd0);
        chk({name, "_done"},      {63'd0, bus.done},      64'd0);
        chk({name, "_rd_addr"},   {59'd0, bus.rd_addr},   64'd0);
    endtask

    initial begin
        int d;
        int b;
        int s;
        int cyc;
        int k;
        int f;
        int l;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.first_addr = '0;
        bus.last_addr  = '0;
        bus.out_ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) x[i] = N'(i * 32'h11);

        // Reset acts before any clock edge.
        #3;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);

        // Full scan, start presented together with reset release.
        bus.out_ready = 1'b1;
        d = done_cnt;
        rst = 1'b0;
        do_start(0, 31, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("first_start_busy", {63'd0, bus.busy}, 64'd1);
        end while (!bus.done && cyc < 200);
        chk("full_start_to_done", 64'(cyc - 1), 64'd64);
        wait_idle(10, "full");
        chk("full_done_count", 64'(done_cnt - d), 64'd1);
        chk("full_all_words", 64'(sb.size()), 64'd0);

        // Backpressure: index 4 held for four cycles.
        tick_p();
        stall_left = 4;
        s = stall4;
        d = done_cnt;
        rdy_mode = 2;
        do_start(3, 5, 1'b1);
        wait_idle(100, "bp");
        chk("bp_stall_cycles", 64'(stall4 - s), 64'd4);
        chk("bp_all_words", 64'(sb.size()), 64'd0);
        chk("bp_done_count", 64'(done_cnt - d), 64'd1);
        rdy_mode = 0;
        tick_p();
        bus.out_ready = 1'b1;

        // Empty scan: no words, one busy cycle, one done.
        b = busy_cyc;
        d = done_cnt;
        do_start(7, 6, 1'b1);
        wait_idle(20, "empty");
        chk("empty_busy_cycles", 64'(busy_cyc - b), 64'd1);
        chk("empty_done_count", 64'(done_cnt - d), 64'd1);

        // Single-word scan.
        tick_p();
        d = done_cnt;
        do_start(9, 9, 1'b1);
        wait_idle(20, "single");
        chk("single_all_words", 64'(sb.size()), 64'd0);
        chk("single_done_count", 64'(done_cnt - d), 64'd1);

        // Snapshot: overwrite the register while its word is held.
        tick_p();
        bus.out_ready = 1'b0;
        do_start(10, 10, 1'b1);
        k = 0;
        while (!bus.out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("snap_valid", {63'd0, bus.out_valid}, 64'd1);
        x[10] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("snap_data", {32'd0, bus.out_data}, 64'h0000_00AA);
        tick_p();
        bus.out_ready = 1'b1;
        wait_idle(20, "snap");
        chk("snap_all_words", 64'(sb.size()), 64'd0);
        x[10] = 32'h0000_00AA;

        // Abort in HOLD of index 2, overriding a handshake that would otherwise occur.
        tick_p();
        do_start(0, 5, 1'b1);
        k = 0;
        while (!(bus.out_valid && bus.out_index == 5'd2) && k < 20) begin
            tick_p();
            k++;
        end
        chk("abort_reached_idx2", {59'd0, bus.out_index}, 64'd2);
        bus.abort = 1'b1;
        d = done_cnt;
        tick_p();
        bus.abort = 1'b0;
        sb.delete();
        chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("abort_out_last", {63'd0, bus.out_last}, 64'd0);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d), 64'd0);

        // Abort in IDLE blocks a same-cycle start.
        tick_p();
        bus.abort = 1'b1;
        do_start(0, 3, 1'b0);
        bus.abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_blocks_start", {63'd0, bus.busy}, 64'd0);

        // Start while busy is ignored; the latched range stays 20..22.
        tick_p();
        bus.out_ready = 1'b0;
        d = done_cnt;
        do_start(20, 22, 1'b1);
        tick_p();
        do_start(0, 1, 1'b0);
        tick_p();
        bus.out_ready = 1'b1;
        wait_idle(40, "busy_start");
        chk("busy_start_all_words", 64'(sb.size()), 64'd0);
        chk("busy_start_done_count", 64'(done_cnt - d), 64'd1);

        // Random contents, ranges and ready pattern.
        for (int it = 0; it < 8; it++) begin
            tick_p();
            for (int j = 0; j < DEPTH; j++) x[j] = $urandom;
            f = int'($urandom_range(0, 31));
            l = int'($urandom_range(0, 31));
            d = done_cnt;
            rdy_mode = 1;
            do_start(f, l, 1'b1);
            wait_idle(400, "rand");
            chk("rand_all_words", 64'(sb.size()), 64'd0);
            chk("rand_done_count", 64'(done_cnt - d), 64'd1);
        end
        rdy_mode = 0;
        tick_p();
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) x[i] = N'(i * 32'h11);

        // Asynchronous reset between edges during the FETCH of index 6.
        tick_p();
        do_start(5, 20, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        sb.delete();
        d = done_cnt;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - d), 64'd0);
        tick_p();
        d = done_cnt;
        do_start(4, 8, 1'b1);
        wait_idle(40, "post_rst");
        chk("post_rst_all_words", 64'(sb.size()), 64'd0);
        chk("post_rst_done_count", 64'(done_cnt - d), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
